// File: rtl/fiber_block_packer_pkg.sv
// Shared constants, state encoding and token helpers for the fiber block packer.
package fiber_block_packer_pkg;

  localparam int WORD_W   = 17;
  localparam int CTRL_BIT = 16;
  localparam int CODE_LSB = 8;
  localparam logic [1:0]        DONE_CODE  = 2'b01;
  localparam logic [WORD_W-1:0] DONE_TOKEN = 17'h10100;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_HDR      = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE_OUT = 2'd3
  } state_e;

  function automatic logic is_ctrl(input logic [WORD_W-1:0] w);
    return w[CTRL_BIT];
  endfunction

  function automatic logic is_done_token(input logic [WORD_W-1:0] w);
    return w[CTRL_BIT] && (w[CODE_LSB +: 2] == DONE_CODE);
  endfunction

endpackage

// File: rtl/fiber_block_packer_if.sv
// Sparse input stream and block-mode output stream of the packer.
interface fiber_block_packer_if;
  import fiber_block_packer_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] blk_data;
  logic              blk_valid;
  logic              blk_ready;

  modport slave (
    input  in_data, in_valid, blk_ready,
    output in_ready, blk_data, blk_valid
  );

  modport master (
    output in_data, in_valid, blk_ready,
    input  in_ready, blk_data, blk_valid
  );

endinterface

// File: rtl/fiber_blk_fifo.sv
// Single-clock fiber buffer; the head word is visible combinationally.
module fiber_blk_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/fiber_block_packer.sv
// Packs a sparse token stream into length-prefixed blocks: header, buffered words, optional done token.
module fiber_block_packer
  import fiber_block_packer_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  fiber_block_packer_if.slave         bus,
  output logic [15:0]                 fiber_count,
  output logic                        done
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LEN_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LEN_ONE  = {{(LW-1){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_next_state;
  logic [LW-1:0]     r_len;
  logic [LW-1:0]     w_len_nxt;
  logic              r_pend_done;
  logic              w_pend_nxt;
  logic [15:0]       r_fiber_count;
  logic [15:0]       w_fc_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_blk_valid;
  logic [WORD_W-1:0] w_blk_data;
  logic              w_out_xfer;
  logic              w_push;
  logic              w_pop;
  logic [WORD_W-1:0] w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  fiber_blk_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.in_data),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FILL;
      r_len         <= LEN_ZERO;
      r_pend_done   <= 1'b0;
      r_fiber_count <= 16'd0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (clk_en) begin
        r_state       <= w_next_state;
        r_len         <= w_len_nxt;
        r_pend_done   <= w_pend_nxt;
        r_fiber_count <= w_fc_nxt;
      end else begin
        r_state <= r_state;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_len_nxt    = r_len;
    w_pend_nxt   = r_pend_done;
    w_fc_nxt     = r_fiber_count;
    w_done_nxt   = 1'b0;
    w_in_ready   = 1'b0;
    w_in_xfer    = 1'b0;
    w_blk_valid  = 1'b0;
    w_blk_data   = {WORD_W{1'b0}};
    w_out_xfer   = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      ST_FILL: begin
        // A full buffer only back-pressures data words; control tokens still close the fiber.
        w_in_ready = !rst && !(bus.in_valid && !is_ctrl(bus.in_data) && w_fifo_full);
        w_in_xfer  = bus.in_valid && w_in_ready && clk_en;
        if (w_in_xfer && !is_ctrl(bus.in_data)) begin
          w_push    = 1'b1;
          w_len_nxt = r_len + LEN_ONE;
        end else if (w_in_xfer && is_done_token(bus.in_data)) begin
          w_pend_nxt   = 1'b1;
          w_next_state = (r_len != LEN_ZERO) ? ST_HDR : ST_DONE_OUT;
        end else if (w_in_xfer) begin
          w_next_state = ST_HDR;
        end else begin
          w_next_state = ST_FILL;
        end
      end
      ST_HDR: begin
        w_blk_valid = !rst;
        w_blk_data  = {{(WORD_W-LW){1'b0}}, r_len};
        w_out_xfer  = w_blk_valid && bus.blk_ready && clk_en;
        if (w_out_xfer) begin
          w_fc_nxt     = r_fiber_count + 16'd1;
          w_next_state = (r_len != LEN_ZERO) ? ST_DRAIN : ST_FILL;
        end else begin
          w_next_state = ST_HDR;
        end
      end
      ST_DRAIN: begin
        w_blk_valid = !rst && !w_fifo_empty;
        w_blk_data  = w_head;
        w_out_xfer  = w_blk_valid && bus.blk_ready && clk_en;
        if (w_out_xfer) begin
          w_pop     = 1'b1;
          w_len_nxt = r_len - LEN_ONE;
          if (r_len == LEN_ONE) begin
            w_next_state = r_pend_done ? ST_DONE_OUT : ST_FILL;
          end else begin
            w_next_state = ST_DRAIN;
          end
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DONE_OUT: begin
        w_blk_valid = !rst;
        w_blk_data  = DONE_TOKEN;
        w_out_xfer  = w_blk_valid && bus.blk_ready && clk_en;
        if (w_out_xfer) begin
          w_done_nxt   = 1'b1;
          w_pend_nxt   = 1'b0;
          w_next_state = ST_FILL;
        end else begin
          w_next_state = ST_DONE_OUT;
        end
      end
      default: begin
        w_next_state = ST_FILL;
      end
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.blk_valid = w_blk_valid;
  assign bus.blk_data  = w_blk_data;
  assign fiber_count   = r_fiber_count;
  assign done          = r_done;

endmodule

// File: tb/tb_fiber_block_packer.sv
// Directed self-checking bench for fiber_block_packer with DEPTH=64.
module tb_fiber_block_packer;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [15:0] fiber_count;
  logic        done;

  fiber_block_packer_if bus();

  fiber_block_packer #(.DEPTH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .bus         (bus),
    .fiber_count (fiber_count),
    .done        (done)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          done_cnt = 0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_data = 17'h0;
  logic [16:0] outq[$];
  int          outcyc[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer: always ready, or toggling ready every cycle.
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) bus.blk_ready = ~bus.blk_ready;
    else bus.blk_ready = 1'b1;
  end

  // Monitor at the falling edge: records transfers, done pulses and stalled-word stability.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (bus.blk_valid !== 1'b1 || bus.blk_data !== prev_data)) stab_err++;
      if (done === 1'b1) done_cnt++;
      if (bus.blk_valid === 1'b1 && bus.blk_ready === 1'b1 && clk_en === 1'b1) begin
        outq.push_back(bus.blk_data);
        outcyc.push_back(cyc);
      end
      prev_stall = (bus.blk_valid === 1'b1) && !(bus.blk_ready === 1'b1 && clk_en === 1'b1);
      prev_data  = bus.blk_data;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    clk_en = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 17'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    outq.delete();
    outcyc.delete();
    done_cnt = 0;
    stab_err = 0;
  endtask

  task automatic send(input logic [16:0] w);
    int k;
    k = 0;
    bus.in_data = w;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!(bus.in_ready === 1'b1 && clk_en === 1'b1) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      n_cmp++; n_mis++;
      $display("FAIL send_timeout: in_ready=%b, required 1 for word %h", bus.in_ready, w);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int k;
    k = 0;
    while (outq.size() < n && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (outq.size() < n) begin
      n_mis++;
      $display("FAIL out_timeout: got %0d words, required %0d", outq.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_en = 1'b0;
    bus.in_data = 17'd5;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_mis++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.blk_valid !== 1'b0) begin n_mis++; $display("FAIL rst_blk_valid: got %b want 0", bus.blk_valid); end
    n_cmp++; if (fiber_count !== 16'd0) begin n_mis++; $display("FAIL rst_fiber_count: got %0d want 0", fiber_count); end
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL rst_done: got %b want 0", done); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clk_en = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [16:0] exp [4] = '{17'd3, 17'd5, 17'd7, 17'd9};
    do_reset();
    send(17'd5); send(17'd7); send(17'd9); send(17'h10000);
    @(negedge clk);
    n_cmp++; if (bus.blk_valid !== 1'b1 || bus.blk_data !== 17'd3) begin
      n_mis++; $display("FAIL hdr_latency: valid=%b data=%h, required 1/%h", bus.blk_valid, bus.blk_data, 17'd3);
    end
    wait_outs(4);
    n_cmp++; if (outq.size() != 4) begin n_mis++; $display("FAIL basic_count: got %0d want 4", outq.size()); end
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      n_cmp++; if (outq[i] !== exp[i]) begin n_mis++; $display("FAIL basic_word%0d: got %h want %h", i, outq[i], exp[i]); end
    end
    if (outcyc.size() >= 4) begin
      n_cmp++; if (outcyc[3] - outcyc[0] != 3) begin n_mis++; $display("FAIL basic_throughput: span %0d cycles want 3", outcyc[3] - outcyc[0]); end
    end
    n_cmp++; if (fiber_count !== 16'd1) begin n_mis++; $display("FAIL basic_fiber_count: got %0d want 1", fiber_count); end
    n_cmp++; if (done_cnt != 0) begin n_mis++; $display("FAIL basic_done: got %0d pulses want 0", done_cnt); end
  endtask

  task automatic test_empty_done();
    logic [16:0] exp [4] = '{17'd0, 17'd1, 17'd4, 17'h10100};
    do_reset();
    send(17'h10000); send(17'd4); send(17'h10000); send(17'h10100);
    wait_outs(4);
    n_cmp++; if (outq.size() != 4) begin n_mis++; $display("FAIL empty_count: got %0d want 4", outq.size()); end
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      n_cmp++; if (outq[i] !== exp[i]) begin n_mis++; $display("FAIL empty_word%0d: got %h want %h", i, outq[i], exp[i]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_mis++; $display("FAIL empty_done: got %0d pulses want 1", done_cnt); end
    n_cmp++; if (fiber_count !== 16'd2) begin n_mis++; $display("FAIL empty_fiber_count: got %0d want 2", fiber_count); end
  endtask

  task automatic test_stall();
    logic [16:0] exp [5] = '{17'd3, 17'h11, 17'h22, 17'h33, 17'h10100};
    do_reset();
    rdy_mode = 1;
    send(17'h11); send(17'h22); send(17'h33); send(17'h10100);
    wait_outs(5);
    rdy_mode = 0;
    n_cmp++; if (outq.size() != 5) begin n_mis++; $display("FAIL stall_count: got %0d want 5", outq.size()); end
    for (int i = 0; i < 5 && i < outq.size(); i++) begin
      n_cmp++; if (outq[i] !== exp[i]) begin n_mis++; $display("FAIL stall_word%0d: got %h want %h", i, outq[i], exp[i]); end
    end
    n_cmp++; if (stab_err != 0) begin n_mis++; $display("FAIL stall_stability: got %0d changes want 0", stab_err); end
    n_cmp++; if (done_cnt != 1) begin n_mis++; $display("FAIL stall_done: got %0d pulses want 1", done_cnt); end
    n_cmp++; if (fiber_count !== 16'd1) begin n_mis++; $display("FAIL stall_fiber_count: got %0d want 1", fiber_count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 64; i++) send(17'(i + 1));
    bus.in_data = 17'd65;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_mis++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    end
    @(posedge clk);
    #1;
    // The stalled data word is withdrawn so the stop token can close the full fiber.
    send(17'h10000);
    wait_outs(65);
    n_cmp++; if (outq.size() < 65 || outq[0] !== 17'd64) begin n_mis++; $display("FAIL full_header: got %h want %h", outq[0], 17'd64); end
    for (int i = 1; i < 65 && i < outq.size(); i++) begin
      n_cmp++; if (outq[i] !== 17'(i)) begin n_mis++; $display("FAIL full_word%0d: got %h want %h", i, outq[i], 17'(i)); end
    end
    for (int i = 65; i <= 70; i++) send(17'(i));
    send(17'h10000);
    wait_outs(72);
    n_cmp++; if (outq.size() != 72) begin n_mis++; $display("FAIL wrap_count: got %0d want 72", outq.size()); end
    if (outq.size() >= 72) begin
      n_cmp++; if (outq[65] !== 17'd6) begin n_mis++; $display("FAIL wrap_header: got %h want 6", outq[65]); end
      for (int j = 0; j < 6; j++) begin
        n_cmp++; if (outq[66 + j] !== 17'(65 + j)) begin n_mis++; $display("FAIL wrap_word%0d: got %h want %h", j, outq[66 + j], 17'(65 + j)); end
      end
    end
    n_cmp++; if (fiber_count !== 16'd2) begin n_mis++; $display("FAIL full_fiber_count: got %0d want 2", fiber_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(17'h21); send(17'h22);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_data = 17'd8;
    bus.in_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.blk_valid !== 1'b0) begin n_mis++; $display("FAIL midrst_blk_valid: got %b want 0", bus.blk_valid); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    send(17'h10000);
    wait_outs(2);
    n_cmp++; if (outq.size() != 2) begin n_mis++; $display("FAIL midrst_count: got %0d want 2", outq.size()); end
    if (outq.size() >= 2) begin
      n_cmp++; if (outq[0] !== 17'd1) begin n_mis++; $display("FAIL midrst_header: got %h want 1", outq[0]); end
      n_cmp++; if (outq[1] !== 17'd8) begin n_mis++; $display("FAIL midrst_word: got %h want 8", outq[1]); end
    end
    n_cmp++; if (fiber_count !== 16'd1) begin n_mis++; $display("FAIL midrst_fiber_count: got %0d want 1", fiber_count); end
  endtask

  task automatic test_clken();
    logic [16:0] exp [6] = '{17'd5, 17'd1, 17'd2, 17'd3, 17'd4, 17'd5};
    int k;
    int sz;
    do_reset();
    for (int i = 1; i <= 5; i++) send(17'(i));
    send(17'h10000);
    k = 0;
    while (outq.size() < 2 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    clk_en = 1'b0;
    sz = outq.size();
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (outq.size() != sz) begin n_mis++; $display("FAIL clken_hold_count: got %0d want %0d", outq.size(), sz); end
    n_cmp++; if (sz < 6 && (bus.blk_valid !== 1'b1 || bus.blk_data !== exp[sz])) begin
      n_mis++; $display("FAIL clken_hold_word: valid=%b data=%h want 1/%h", bus.blk_valid, bus.blk_data, exp[sz]);
    end
    clk_en = 1'b1;
    wait_outs(6);
    n_cmp++; if (outq.size() != 6) begin n_mis++; $display("FAIL clken_count: got %0d want 6", outq.size()); end
    for (int i = 0; i < 6 && i < outq.size(); i++) begin
      n_cmp++; if (outq[i] !== exp[i]) begin n_mis++; $display("FAIL clken_word%0d: got %h want %h", i, outq[i], exp[i]); end
    end
    n_cmp++; if (stab_err != 0) begin n_mis++; $display("FAIL clken_stability: got %0d changes want 0", stab_err); end
    n_cmp++; if (fiber_count !== 16'd1) begin n_mis++; $display("FAIL clken_fiber_count: got %0d want 1", fiber_count); end
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 17'h0;
    bus.blk_ready = 1'b1;
    test_reset();
    test_basic();
    test_empty_done();
    test_stall();
    test_full();
    test_reset_mid();
    test_clken();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fiber_block_packer.md
FIBER_BLOCK_PACKER -- requirements
Module: fiber_block_packer

Interface
REQ-001 Parameter DEPTH, default 64: fiber buffer capacity in words, a power of two.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 clk_en  input  1  when low, all state holds and no handshake completes.
REQ-005 in_data  input  17  sparse stream word; bit16=1 marks a control token.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  packer accepts in_data this cycle.
REQ-008 blk_data  output  17  block-mode stream word toward the write-scanner block_wr_in port.
REQ-009 blk_valid  output  1  blk_data valid.
REQ-010 blk_ready  input  1  consumer accepts blk_data.
REQ-011 fiber_count  output  16  fibers emitted since reset; wraps at 2^16.
REQ-012 done  output  1  one-cycle pulse when the done token is accepted downstream.

Function
REQ-013 Handshake: a transfer occurs only when valid, ready and clk_en are all high in the same cycle; valid, once asserted, holds with stable data until the transfer occurs.
REQ-014 Token decode: bit16=0 is a data word; bit16=1 with bits[9:8]=2'b01 is the done token (canonical 17'h10100); any other bit16=1 word is a stop token.
REQ-015 States: FILL, HDR, DRAIN, DONE_OUT.
REQ-016 FILL: in_ready=1 except when a data word is presented with the buffer holding DEPTH words; an accepted data word is pushed and len increments.
REQ-017 FILL: an accepted stop token is not stored; the next state is HDR.
REQ-018 FILL: an accepted done token sets pend_done; the next state is HDR if len>0, else DONE_OUT.
REQ-019 HDR: blk_data={1'b0, len zero-extended}, blk_valid=1, in_ready=0; on transfer, fiber_count increments and the next state is DRAIN if len>0, else FILL.
REQ-020 DRAIN: blk_data=buffer head, blk_valid=1, in_ready=0; each transfer pops one word; on the transfer of the last word, len clears and the next state is DONE_OUT if pend_done, else FILL.
REQ-021 DONE_OUT: blk_data=17'h10100, blk_valid=1; on transfer, done pulses for one cycle, pend_done clears and the next state is FILL.
REQ-022 Latency: the header is valid in the cycle after the terminating token is accepted; output throughput is one word per cycle under continuous blk_ready.
REQ-023 An empty fiber (stop token with len=0) emits exactly one header word of 0.
REQ-024 A full buffer (len=DEPTH) deasserts in_ready for data words only; control tokens remain acceptable; no word is ever dropped or overwritten.
REQ-025 len is $clog2(DEPTH)+1 bits; the header reports DEPTH exactly when the buffer is full.
REQ-026 Buffer pointers wrap modulo DEPTH without loss across successive fibers.

Reset
REQ-027 While rst is high at a clock edge: state=FILL, len=0, pointers=0, pend_done=0, fiber_count=0, done=0, blk_valid=0, in_ready=0.
REQ-028 rst overrides clk_en.
REQ-029 rst mid-fiber discards buffered words with no partial output; the first cycle after reset accepts a new fiber.

Structure
REQ-030 A shared package holds the token constants (DONE_TOKEN=17'h10100, control bit index, done-code field) and the state enum.
REQ-031 The buffer is one sub-module, fiber_blk_fifo: synchronous single-clock FIFO, DEPTH x 17, full/empty flags, no read latency (head word visible combinationally).
REQ-032 The FSM, len counter and output multiplexing reside in fiber_block_packer.

Verification
REQ-033 Input 5,7,9,stop(17'h10000), blk_ready=1 -> output 3,5,7,9; fiber_count=1.
REQ-034 Input stop, 4, stop, done -> output 0, 1, 4, 17'h10100; done pulses once; fiber_count=2.
REQ-035 Input 70 data words with DEPTH=64 and blk_ready=1 -> in_ready low on the 65th word until the stop token is accepted and the fiber drains.
REQ-036 Input 3 data words then done with no stop, blk_ready toggling 1/0 -> output 3, d0, d1, d2, 17'h10100; each word stable while stalled.
REQ-037 rst asserted after 2 of 4 data words are accepted, then input 8, stop -> output 1, 8 only.
REQ-038 clk_en low for 5 cycles during DRAIN -> no pops and no state change; the stream resumes identically afterwards.
